fir_sample_pacer: RTL and testbench

//  Streaming front/back end for the resource-shared FIR. It accepts samples from an upstream

---
 rtl/fir_sample_pacer_if.sv | 30 +++
 rtl/fir_sample_pacer.sv | 194 +++++++++++++++++++
 tb/tb_fir_sample_pacer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_pacer_if.sv
`default_nettype none
// ============================================================================
// Interface : fir_sample_pacer_if
// Purpose   : Upstream sample stream and downstream result stream of the
//             FIR sample pacer, both valid/ready.
// Revision  : 1.0 - initial release
// ============================================================================
interface fir_sample_pacer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    // Producer of samples / consumer of results
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

    // The pacer itself
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface
`default_nettype wire

// File: rtl/fir_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : fir_sample_pacer
// Purpose  : Buffers an upstream sample stream, presents one sample to the
//            resource-shared FIR per CYCLES_PER_SAMPLE-clock slot, captures
//            each FIR result at the slot boundary and returns the results on
//            a downstream valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sample_pacer #(
    parameter int DATA_W            = 16,
    parameter int CYCLES_PER_SAMPLE = 20,
    parameter int IN_DEPTH          = 8,
    parameter int OUT_DEPTH         = 8,
    parameter int DROP_W            = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fir_sample_pacer_if.slave    stream,
    output logic [DATA_W-1:0]    fir_data_in,
    input  logic [DATA_W-1:0]    fir_data_out,
    output logic                 underrun,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_count
);
    localparam int                SLOT_W    = $clog2(CYCLES_PER_SAMPLE);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLES_PER_SAMPLE - 1);
    localparam int                IAW       = $clog2(IN_DEPTH);
    localparam int                OAW       = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // ---------------- slot scheduler state ----------------
    state_t              state_q;
    logic [SLOT_W-1:0]   slot_cnt_q;
    logic [DATA_W-1:0]   fir_data_in_q;
    logic [DATA_W-1:0]   cap_data_q;
    logic                cap_vld_q;
    logic                underrun_q;
    logic                boundary;

    // ---------------- input FIFO ----------------
    logic [DATA_W-1:0]   in_mem [IN_DEPTH];
    logic [IAW:0]        in_wr_q, in_rd_q, in_wr_d, in_rd_d, in_cnt_d;
    logic                s_ready_q;
    logic                in_empty, in_push, in_pop;
    logic [DATA_W-1:0]   in_head;

    // ---------------- output FIFO + head register ----------------
    logic [DATA_W-1:0]   out_mem [OUT_DEPTH];
    logic [OAW:0]        out_wr_q, out_rd_q, out_cnt;
    logic [OAW+1:0]      out_occ;
    logic                m_valid_q;
    logic [DATA_W-1:0]   m_data_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   drop_count_q;
    logic                out_pop, out_load, out_full, out_push, out_drop;

    assign boundary = (state_q != ST_IDLE) && (slot_cnt_q == SLOT_LAST);

    // Input side: registered ready guarantees a push never lands on a full FIFO
    assign in_empty = (in_wr_q == in_rd_q);
    assign in_push  = stream.s_valid && s_ready_q;
    assign in_pop   = boundary && enable && !in_empty;
    assign in_head  = in_mem[in_rd_q[IAW-1:0]];
    assign in_wr_d  = in_wr_q + (IAW+1)'(in_push);
    assign in_rd_d  = in_rd_q + (IAW+1)'(in_pop);
    assign in_cnt_d = in_wr_d - in_rd_d;

    // Output side: occupancy counts the head register too, so total storage is OUT_DEPTH
    assign out_cnt  = out_wr_q - out_rd_q;
    assign out_pop  = m_valid_q && stream.m_ready;
    assign out_load = (out_cnt != '0) && (!m_valid_q || stream.m_ready);
    assign out_occ  = {1'b0, out_cnt} + (OAW+2)'(m_valid_q) - (OAW+2)'(out_pop);
    assign out_full = (out_occ == (OAW+2)'(OUT_DEPTH));
    assign out_push = cap_vld_q && !out_full;
    assign out_drop = cap_vld_q && out_full;

    assign stream.s_ready = s_ready_q;
    assign stream.m_valid = m_valid_q;
    assign stream.m_data  = m_data_q;
    assign fir_data_in    = fir_data_in_q;
    assign underrun       = underrun_q;
    assign overflow       = overflow_q;
    assign drop_count     = drop_count_q;

    // Slot timer and FSM: load one sample per slot, capture the previous slot's FIR result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slot_cnt_q    <= '0;
            fir_data_in_q <= '0;
            cap_data_q    <= '0;
            cap_vld_q     <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cap_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
            if (state_q == ST_IDLE || boundary) begin
                slot_cnt_q <= '0;
            end else begin
                slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (boundary) begin
                        if (!enable) begin
                            state_q <= ST_IDLE;
                        end else if (!in_empty) begin
                            fir_data_in_q <= in_head;
                            state_q       <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        cap_data_q    <= fir_data_out;
                        cap_vld_q     <= 1'b1;
                        underrun_q    <= in_empty;
                        fir_data_in_q <= in_pop ? in_head : '0;
                        state_q       <= enable ? ST_RUN : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Input FIFO pointers and registered not-full flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            s_ready_q <= 1'b1;
        end else begin
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            s_ready_q <= (in_cnt_d != (IAW+1)'(IN_DEPTH));
        end
    end

    // Input FIFO storage; contents are discarded on reset through the pointers
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_q[IAW-1:0]] <= stream.s_data;
        end
    end

    // Output FIFO pointers, registered head stage and drop accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr_q     <= '0;
            out_rd_q     <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (out_push) begin
                out_wr_q <= out_wr_q + (OAW+1)'(1);
            end
            if (out_load) begin
                out_rd_q  <= out_rd_q + (OAW+1)'(1);
                m_data_q  <= out_mem[out_rd_q[OAW-1:0]];
                m_valid_q <= 1'b1;
            end else if (out_pop) begin
                m_valid_q <= 1'b0;
            end
            overflow_q <= out_drop;
            if (out_drop && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + DROP_W'(1);
            end
        end
    end

    // Output FIFO storage
    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wr_q[OAW-1:0]] <= cap_data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_sample_pacer
// Purpose  : Directed self-checking bench for fir_sample_pacer with a stub
//            FIR that returns fir_data_in + 0x100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_sample_pacer;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] fir_data_in;
    logic [15:0] fir_data_out;
    logic        underrun;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int e0           = 0;
    int n_unr        = 0;
    int n_ovf        = 0;
    int hold_bad     = 0;

    fir_sample_pacer_if #(.DATA_W(16)) bus ();

    fir_sample_pacer #(
        .DATA_W            (16),
        .CYCLES_PER_SAMPLE (20),
        .IN_DEPTH          (8),
        .OUT_DEPTH         (8),
        .DROP_W            (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .stream       (bus),
        .fir_data_in  (fir_data_in),
        .fir_data_out (fir_data_out),
        .underrun     (underrun),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    // Stub FIR: result of the presented sample is sample + 0x100
    assign fir_data_out = fir_data_in + 16'h0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (underrun === 1'b1) n_unr++;
        if (overflow === 1'b1) n_ovf++;
    endtask

    task automatic run_to(input int n);
        while (cyc < e0 + n) tick();
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'h0000;
        bus.m_ready = 1'b1;
        tick();
        tick();
        check("rst_s_ready",  32'(bus.s_ready), 1);
        check("rst_m_valid",  32'(bus.m_valid), 0);
        check("rst_m_data",   32'(bus.m_data), 0);
        check("rst_fir_in",   32'(fir_data_in), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop",     32'(drop_count), 0);
        reset = 1'b0;
        tick(); tick(); tick();

        // 1: enable and push 1..4 back-to-back
        enable      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h0001;
        tick();
        e0 = cyc;
        check("t1_s_ready_e0", 32'(bus.s_ready), 1);
        bus.s_data = 16'h0002; tick();
        bus.s_data = 16'h0003; tick();
        bus.s_data = 16'h0004; tick();
        bus.s_valid = 1'b0;
        check("t1_s_ready_e3", 32'(bus.s_ready), 1);
        run_to(19); check("t1_fir_in_e19", 32'(fir_data_in), 0);
        run_to(20); check("t1_fir_in_e20", 32'(fir_data_in), 1);
        run_to(40); check("t1_fir_in_e40", 32'(fir_data_in), 2);
                    check("t2_m_valid_e40", 32'(bus.m_valid), 0);

        // 2: results 0x101..0x103, one clock each, 1 slot + 2 clks after load
        run_to(41); check("t2_m_valid_e41", 32'(bus.m_valid), 0);
        run_to(42); check("t2_m_valid_e42", 32'(bus.m_valid), 1);
                    check("t2_m_data_0101", 32'(bus.m_data), 32'h0101);
        run_to(43); check("t2_m_valid_e43", 32'(bus.m_valid), 0);
        run_to(60); check("t1_fir_in_e60", 32'(fir_data_in), 3);
        run_to(62); check("t2_m_data_0102", 32'(bus.m_data), 32'h0102);
                    check("t2_m_valid_e62", 32'(bus.m_valid), 1);
        run_to(63); check("t2_m_valid_e63", 32'(bus.m_valid), 0);
        run_to(80); check("t1_fir_in_e80", 32'(fir_data_in), 4);
        run_to(82); check("t2_m_data_0103", 32'(bus.m_data), 32'h0103);
        run_to(99); check("t2_no_underrun", 32'(n_unr), 0);

        // 3: input FIFO drained -> zero loaded, one-clock underrun
        run_to(100); check("t3_fir_in_zero", 32'(fir_data_in), 0);
                     check("t3_underrun_hi", 32'(underrun), 1);
        run_to(101); check("t3_underrun_lo", 32'(underrun), 0);
                     check("t3_underrun_cnt", 32'(n_unr), 1);
        run_to(102); check("t3_m_data_0104", 32'(bus.m_data), 32'h0104);
        run_to(103);

        // 4: stall the output for 10 captures (E120..E300)
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h0055; tick();
        bus.s_data  = 16'h0056; tick();
        bus.s_data  = 16'h0057; tick();
        bus.s_valid = 1'b0;
        while (cyc < e0 + 301) begin
            tick();
            if (cyc >= e0 + 122 && (bus.m_valid !== 1'b1 || bus.m_data !== 16'h0100)) hold_bad++;
        end
        check("t4_head_hold", 32'(hold_bad), 0);
        check("t4_ovf_pulses", 32'(n_ovf), 2);
        check("t4_drop_count", 32'(drop_count), 2);
        bus.m_ready = 1'b1;
        tick();
        check("t4_next_head", 32'(bus.m_data), 32'h0155);
        check("t4_next_valid", 32'(bus.m_valid), 1);

        // Return to IDLE and drain
        enable = 1'b0;
        run_to(360);
        check("t5_pre_m_valid", 32'(bus.m_valid), 0);
        check("t5_pre_fir_in",  32'(fir_data_in), 0);
        check("t5_pre_s_ready", 32'(bus.s_ready), 1);

        // 5: nine pushes while IDLE
        bus.s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.s_data = 16'(16'h00A0 + i);
            tick();
        end
        check("t5_full_after_8", 32'(bus.s_ready), 0);
        bus.s_data = 16'h00A8;
        tick(); tick();
        check("t5_ninth_held", 32'(bus.s_ready), 0);
        enable = 1'b1;
        tick();
        e0 = cyc;
        run_to(19); check("t5_s_ready_e19", 32'(bus.s_ready), 0);
        run_to(20); check("t5_fir_in_a0", 32'(fir_data_in), 32'h00A0);
                    check("t5_s_ready_e20", 32'(bus.s_ready), 1);
        run_to(21); check("t5_s_ready_e21", 32'(bus.s_ready), 0);
        bus.s_valid = 1'b0;
        run_to(160); check("t5_fir_in_a7", 32'(fir_data_in), 32'h00A7);
        bus.m_ready = 1'b0;
        run_to(180); check("t5_fir_in_a8", 32'(fir_data_in), 32'h00A8);
                     check("t6_pre_m_data", 32'(bus.m_data), 32'h01A6);

        // 6: partly fill both FIFOs, reset at slot_cnt = 7
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h00B0; tick();
        bus.s_data  = 16'h00B1; tick();
        bus.s_valid = 1'b0;
        run_to(187);
        check("t6_pre_drop",    32'(drop_count), 2);
        check("t6_pre_m_valid", 32'(bus.m_valid), 1);
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        check("t6_rst_m_valid", 32'(bus.m_valid), 0);
        check("t6_rst_fir_in",  32'(fir_data_in), 0);
        check("t6_rst_drop",    32'(drop_count), 0);
        check("t6_rst_s_ready", 32'(bus.s_ready), 1);
        check("t6_rst_m_data",  32'(bus.m_data), 0);
        tick(); tick();
        reset = 1'b0;
        repeat (25) tick();
        check("t6_idle_fir_in",  32'(fir_data_in), 0);
        check("t6_idle_m_valid", 32'(bus.m_valid), 0);
        check("t6_idle_s_ready", 32'(bus.s_ready), 1);
        enable      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h00C3;
        tick();
        e0 = cyc;
        bus.s_valid = 1'b0;
        run_to(19); check("t6_restart_e19", 32'(fir_data_in), 0);
        run_to(20); check("t6_restart_c3",  32'(fir_data_in), 32'h00C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
`default_nettype wire
